fir_mac_filter: RTL and testbench



---
 rtl/fir_mac_filter.sv | 132 +++++++++++++
 tb/tb_fir_mac_filter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_filter.sv
// fir_mac_filter: DEPTH-tap FIR, one shared multiply-accumulate per clock.
// Define FIR_SATURATE_EN to clamp results; otherwise results wrap.
module fir_mac_filter #(
  parameter int WIDTH  = 12,
  parameter int DEPTH  = 8,
  parameter int COEF_W = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  input  logic [DEPTH*COEF_W-1:0] kernel,
  input  logic                    toggle_en,
  output logic signed [WIDTH-1:0] sample_out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    enabled,
  output logic                    overrun
);

  localparam int PW = WIDTH + COEF_W;
  localparam int AW = PW + $clog2(DEPTH);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  localparam logic signed [AW-1:0] RND =
    AW'(64'sd1 <<< (COEF_W - 2));

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_hist [DEPTH];
  logic signed [AW-1:0]    r_acc;
  logic [IW-1:0]           r_idx;
  logic                    r_enabled;
  logic                    r_out_valid;
  logic                    r_overrun;
  logic signed [WIDTH-1:0] r_out;

  logic signed [WIDTH-1:0]  w_h;
  logic signed [COEF_W-1:0] w_k;
  logic signed [PW-1:0]     w_prod;
  logic signed [AW-1:0]     w_acc_nx;
  logic signed [WIDTH-1:0]  w_res;
  logic                     w_accept;

  assign w_accept = sample_valid && (r_state == S_IDLE);
  assign w_h      = r_hist[r_idx];
  assign w_k      = kernel[r_idx*COEF_W +: COEF_W];
  assign w_prod   = w_h * w_k;
  assign w_acc_nx = r_acc + AW'(w_prod);

`ifdef FIR_SATURATE_EN
  localparam logic signed [AW-1:0] MAXV =
    AW'(2**(WIDTH-1) - 1);
  localparam logic signed [AW-1:0] MINV = -MAXV - 1;
  logic signed [AW-1:0] w_shr;

  assign w_shr = (w_acc_nx + RND) >>> (COEF_W - 1);

  always_comb begin
    w_res = w_shr[WIDTH-1:0];
    if (w_shr > MAXV)
      w_res = MAXV[WIDTH-1:0];
    else if (w_shr < MINV)
      w_res = MINV[WIDTH-1:0];
  end
`else
  assign w_res =
    WIDTH'((w_acc_nx + RND) >>> (COEF_W - 1));
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_idx       <= '0;
      r_enabled   <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_out       <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_hist[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_overrun   <= sample_valid &&
                     (r_state != S_IDLE);
      if (toggle_en)
        r_enabled <= !r_enabled;
      if (w_accept) begin
        r_hist[0] <= sample_in;
        for (int i = 1; i < DEPTH; i++)
          r_hist[i] <= r_hist[i-1];
      end
      // Mode is latched by the IDLE branch taken.
      unique case (r_state)
        S_IDLE: begin
          if (w_accept && r_enabled) begin
            r_state <= S_MAC;
            r_acc   <= '0;
            r_idx   <= '0;
          end else if (w_accept) begin
            r_state     <= S_OUT;
            r_out       <= sample_in;
            r_out_valid <= 1'b1;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_nx;
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_state     <= S_OUT;
            r_out       <= w_res;
            r_out_valid <= 1'b1;
          end
        end
        S_OUT:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sample_out = r_out;
  assign out_valid  = r_out_valid;
  assign busy       = (r_state != S_IDLE);
  assign enabled    = r_enabled;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_fir_mac_filter.sv
// tb_fir_mac_filter: random and directed checks of fir_mac_filter
// against an array-based arithmetic reference model.
module tb_fir_mac_filter;

  localparam int W = 12;
  localparam int D = 8;
  localparam int C = 12;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic signed [W-1:0]   sample_in = '0;
  logic                  sample_valid = 1'b0;
  logic [D*C-1:0]        kernel = '0;
  logic                  toggle_en = 1'b0;
  logic signed [W-1:0]   sample_out;
  logic                  out_valid;
  logic                  busy;
  logic                  enabled;
  logic                  overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int hist [D];
  int coef [D];
  bit mdl_en = 1'b0;

  fir_mac_filter #(.WIDTH(W), .DEPTH(D), .COEF_W(C)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .kernel       (kernel),
    .toggle_en    (toggle_en),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .enabled      (enabled),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x);
    for (int i = D - 1; i > 0; i--)
      hist[i] = hist[i-1];
    hist[0] = x;
  endtask

  function automatic int ref_out();
    longint s;
    longint r;
    s = 0;
    for (int i = 0; i < D; i++)
      s += longint'(hist[i]) * longint'(coef[i]);
    r = (s + (longint'(1) << (C - 2))) >>> (C - 1);
`ifdef FIR_SATURATE_EN
    if (r > (2**(W-1) - 1)) r = 2**(W-1) - 1;
    if (r < -(2**(W-1))) r = -(2**(W-1));
`else
    r = r % (longint'(1) << W);
    if (r < 0) r += (longint'(1) << W);
    if (r >= (longint'(1) << (W - 1)))
      r -= (longint'(1) << W);
`endif
    return int'(r);
  endfunction

  task automatic load_kernel();
    int c;
    for (int i = 0; i < D; i++) begin
      c = coef[i];
      kernel[i*C +: C] = c[C-1:0];
    end
  endtask

  task automatic toggle();
    toggle_en = 1'b1;
    step();
    toggle_en = 1'b0;
    mdl_en = !mdl_en;
    check("toggle_en", enabled, mdl_en);
  endtask

  task automatic send(input int x, input string tag);
    int exp_v;
    int exp_lat;
    int n;
    bit seen;
    push(x);
    if (mdl_en) begin
      exp_v   = ref_out();
      exp_lat = D + 1;
    end else begin
      exp_v   = x;
      exp_lat = 1;
    end
    sample_in    = x[W-1:0];
    sample_valid = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      step();
      n++;
      sample_valid = 1'b0;
      if (n < exp_lat)
        check({tag, "_busy"}, busy, 1);
      if (out_valid) seen = 1'b1;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_val"}, sample_out, exp_v);
    step();
    check({tag, "_pulse"}, out_valid, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_hold"}, sample_out, exp_v);
  endtask

  initial begin
    int a;
    int b;
    int ov_cnt;
    int ov_cyc;
    int ov_val;
    int or_cnt;
    int or_cyc;
    int exp_a;

    for (int i = 0; i < D; i++) begin
      hist[i] = 0;
      coef[i] = 0;
    end
    repeat (3) step();
    check("rst_out", sample_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_en", enabled, 0);
    check("rst_ovr", overrun, 0);
    reset_n = 1'b1;
    step();

    send(-300, "bypass");

    toggle();
    coef[0] = 1024;
    load_kernel();
    send(1000, "imp_pos");
    send(-1000, "imp_neg");

    for (int i = 0; i < D; i++) coef[i] = 256;
    load_kernel();
    for (int i = 0; i < 8; i++) begin
      send(800, "mavg");
      step();
    end

    for (int i = 0; i < D; i++) coef[i] = 2047;
    load_kernel();
    for (int i = 0; i < 8; i++) send(2047, "sat_hi");
    for (int i = 0; i < 8; i++) send(-2048, "sat_lo");

    for (int i = 0; i < D; i++)
      coef[i] = int'($urandom_range(0, 4095)) - 2048;
    load_kernel();
    for (int j = 0; j < 24; j++) begin
      if ($urandom_range(0, 3) == 0) toggle();
      if (j == 12) begin
        for (int i = 0; i < D; i++)
          coef[i] = int'($urandom_range(0, 1023)) - 512;
        load_kernel();
      end
      send(int'($urandom_range(0, 4095)) - 2048, "rnd");
    end

    if (!mdl_en) toggle();
    a = int'($urandom_range(0, 2047)) - 1024;
    b = int'($urandom_range(0, 2047)) - 1024;
    push(a);
    exp_a = ref_out();
    ov_cnt = 0; ov_cyc = -1; ov_val = 0;
    or_cnt = 0; or_cyc = -1;
    for (int c = 0; c < 16; c++) begin
      sample_valid = (c == 0) || (c == 3);
      toggle_en    = (c == 2);
      sample_in    = (c == 0) ? a[W-1:0] : b[W-1:0];
      step();
      if (out_valid) begin
        ov_cnt++;
        ov_cyc = c + 1;
        ov_val = int'(sample_out);
      end
      if (overrun) begin
        or_cnt++;
        or_cyc = c + 1;
      end
      if (c + 1 == 3)
        check("ovr_en_now", enabled, 0);
    end
    sample_valid = 1'b0;
    toggle_en = 1'b0;
    mdl_en = 1'b0;
    check("ovr_outcnt", ov_cnt, 1);
    check("ovr_outcyc", ov_cyc, D + 1);
    check("ovr_outval", ov_val, exp_a);
    check("ovr_cnt", or_cnt, 1);
    check("ovr_cyc", or_cyc, 4);
    send(b, "post_ovr");

    toggle();
    sample_in = 12'sd77;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    ov_cnt = 0;
    repeat (3) begin
      step();
      if (out_valid) ov_cnt++;
    end
    reset_n = 1'b0;
    repeat (2) begin
      step();
      if (out_valid) ov_cnt++;
    end
    check("mid_rst_out", sample_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_en", enabled, 0);
    check("mid_rst_ovr", overrun, 0);
    reset_n = 1'b1;
    repeat (12) begin
      step();
      if (out_valid) ov_cnt++;
    end
    check("mid_rst_novalid", ov_cnt, 0);
    for (int i = 0; i < D; i++) hist[i] = 0;
    mdl_en = 1'b0;

    toggle();
    for (int i = 0; i < D; i++) coef[i] = 1500;
    load_kernel();
    send(5, "hist_clr");

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
